// File: rtl/imem_refill_arbiter_pkg.sv
// Shared constants, state/owner encodings and sizing helper for the I-memory refill arbiter.
package imem_refill_arbiter_pkg;

    localparam int IMEM_BLOCK_ADDR_SIZE = 8;
    localparam int IBLOCK_SIZE_BITS     = 32;
    localparam int IARB_TIMEOUT         = 64;

    typedef enum logic [1:0] {
        IARB_IDLE = 2'd0,
        IARB_READ = 2'd1,
        IARB_RESP = 2'd2,
        IARB_GAP  = 2'd3
    } iarb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DM   = 2'd1,
        OWN_PF   = 2'd2
    } iarb_owner_e;

    // Counter width able to reach cycles-1; never narrower than one bit.
    function automatic int iarb_cnt_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/imem_refill_arbiter_counter.sv
// Timeout counter: free-running up-counter with a synchronous clear and a count enable.
module imem_refill_arbiter_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/imem_refill_arbiter.sv
// Shares the single instruction-memory read port between the demand-miss and prefetch
// requesters, with demand priority, prefetch promotion/abort, read timeout and an idle gap.
module imem_refill_arbiter
    import imem_refill_arbiter_pkg::*;
#(
    parameter int ADDR_W         = IMEM_BLOCK_ADDR_SIZE,
    parameter int DATA_W         = IBLOCK_SIZE_BITS,
    parameter int TIMEOUT_CYCLES = IARB_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    output logic              dm_ack_o,
    output logic              dm_valid_o,
    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    output logic              pf_ack_o,
    output logic              pf_valid_o,
    output logic              pf_dropped_o,
    output logic              resp_err_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              busy_o
);

    localparam int              CNT_W    = iarb_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    iarb_state_e       state_q;
    iarb_owner_e       owner_q;
    iarb_owner_e       owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_ren_q;
    logic              dm_ack_q;
    logic              pf_ack_q;
    logic              dm_valid_q;
    logic              pf_valid_q;
    logic              pf_dropped_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;

    logic [CNT_W-1:0]  tmo_cnt_s;
    logic              dm_hit_s;
    logic              promote_s;
    logic              abort_s;
    logic              mem_done_s;
    logic              timeout_s;

    // Counts only the cycles the read enable is actually high, so the limit measures memory wait.
    imem_refill_arbiter_counter #(
        .WIDTH (CNT_W)
    ) u_tmo_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear_i (state_q != IARB_READ),
        .en_i    (mem_ren_q),
        .count_o (tmo_cnt_s)
    );

    // A demand hitting an in-flight prefetch either takes it over (same block) or aborts it.
    assign dm_hit_s   = (state_q == IARB_READ) && (owner_q == OWN_PF) && dm_req_i;
    assign promote_s  = dm_hit_s && (dm_addr_i == addr_q);
    assign abort_s    = dm_hit_s && (dm_addr_i != addr_q);
    assign owner_d    = promote_s ? OWN_DM : owner_q;
    assign mem_done_s = mem_ren_q && mem_ready_i;
    assign timeout_s  = mem_ren_q && (tmo_cnt_s == CNT_LAST);

    // Arbitration FSM with registered handshake, memory and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IARB_IDLE;
            owner_q      <= OWN_NONE;
            addr_q       <= '0;
            mem_ren_q    <= 1'b0;
            dm_ack_q     <= 1'b0;
            pf_ack_q     <= 1'b0;
            dm_valid_q   <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_dropped_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            dm_ack_q     <= 1'b0;
            pf_ack_q     <= 1'b0;
            dm_valid_q   <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_dropped_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IARB_IDLE: begin
                    mem_ren_q <= 1'b0;
                    if (dm_req_i) begin
                        dm_ack_q <= 1'b1;
                        addr_q   <= dm_addr_i;
                        owner_q  <= OWN_DM;
                        state_q  <= IARB_READ;
                    end else if (pf_req_i) begin
                        pf_ack_q <= 1'b1;
                        addr_q   <= pf_addr_i;
                        owner_q  <= OWN_PF;
                        state_q  <= IARB_READ;
                    end else begin
                        owner_q  <= OWN_NONE;
                    end
                end
                IARB_READ: begin
                    dm_ack_q     <= promote_s;
                    pf_dropped_q <= promote_s;
                    owner_q      <= owner_d;
                    if (mem_done_s) begin
                        resp_data_q <= mem_dout_i;
                        mem_ren_q   <= 1'b0;
                        dm_valid_q  <= (owner_d == OWN_DM);
                        pf_valid_q  <= (owner_d == OWN_PF);
                        state_q     <= IARB_RESP;
                    end else if (abort_s) begin
                        pf_dropped_q <= 1'b1;
                        mem_ren_q    <= 1'b0;
                        owner_q      <= OWN_NONE;
                        state_q      <= IARB_GAP;
                    end else if (timeout_s) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                        mem_ren_q   <= 1'b0;
                        dm_valid_q  <= (owner_d == OWN_DM);
                        pf_valid_q  <= (owner_d == OWN_PF);
                        state_q     <= IARB_RESP;
                    end else begin
                        mem_ren_q   <= 1'b1;
                    end
                end
                IARB_RESP: begin
                    mem_ren_q <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= IARB_GAP;
                end
                IARB_GAP: begin
                    mem_ren_q <= 1'b0;
                    state_q   <= IARB_IDLE;
                end
                default: begin
                    mem_ren_q <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= IARB_IDLE;
                end
            endcase
        end
    end

    assign dm_ack_o     = dm_ack_q;
    assign pf_ack_o     = pf_ack_q;
    assign dm_valid_o   = dm_valid_q;
    assign pf_valid_o   = pf_valid_q;
    assign pf_dropped_o = pf_dropped_q;
    assign resp_err_o   = resp_err_q;
    assign resp_data_o  = resp_data_q;
    assign mem_ren_o    = mem_ren_q;
    assign mem_addr_o   = addr_q;
    assign busy_o       = (state_q != IARB_IDLE);

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Scoreboard bench for imem_refill_arbiter with a fixed-delay block memory model.
module tb_imem_refill_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int MEM_DELAY = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dm_req = 1'b0, pf_req = 1'b0;
    logic [AW-1:0] dm_addr = '0, pf_addr = '0;
    logic          dm_ack, dm_valid, pf_ack, pf_valid, pf_dropped, resp_err;
    logic [DW-1:0] resp_data;
    logic          mem_ren, mem_ready, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          stub_low = 1'b0;
    logic [1:0]    dcnt = 2'd0;

    typedef struct {
        logic [1:0]    kind;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0, cyc = 0, drops = 0;

    imem_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_ack_o(dm_ack), .dm_valid_o(dm_valid),
        .pf_req_i(pf_req), .pf_addr_i(pf_addr), .pf_ack_o(pf_ack), .pf_valid_o(pf_valid),
        .pf_dropped_o(pf_dropped), .resp_err_o(resp_err), .resp_data_o(resp_data),
        .mem_ren_o(mem_ren), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready),
        .mem_dout_i(mem_dout), .busy_o(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8'hC0, a, ~a, a ^ 8'h5A};
    endfunction

    // Memory: data valid after MEM_DELAY cycles of continuous read enable.
    always @(posedge clock) begin
        if (!mem_ren) dcnt <= 2'd0;
        else if (dcnt != 2'(MEM_DELAY)) dcnt <= dcnt + 2'd1;
    end
    assign mem_ready = mem_ren && (dcnt == 2'(MEM_DELAY)) && !stub_low;
    assign mem_dout  = mem_ready ? word(mem_addr) : 32'hDEAD_BEEF;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return dm_ack;
            1: return pf_ack;
            2: return dm_valid;
            3: return pf_valid;
            4: return mem_ren;
            5: return pf_dropped;
            6: return mem_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int w, input int budget, output int at);
        int n = 0;
        @(negedge clock);
        while (!sig(w) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!sig(w)) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        at = cyc;
    endtask

    // Response monitor: every valid pulse is matched against the scoreboard head.
    always @(negedge clock) begin
        if (pf_dropped) drops <= drops + 1;
        if (dm_valid || pf_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", {62'd0, dm_valid, pf_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("resp_kind", {62'd0, dm_valid, pf_valid}, {62'd0, e.kind});
                check_val("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                check_val("resp_data", {32'd0, resp_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r, m, v, lows, n;
        logic [AW-1:0] a;

        // Reset state
        repeat (2) @(negedge clock);
        check_val("reset_outputs", {56'd0, dm_ack, dm_valid, pf_ack, pf_valid, pf_dropped, resp_err, mem_ren, busy}, 64'd0);
        check_val("reset_data", {32'd0, resp_data}, 64'd0);
        @(posedge clock); #1 reset = 1'b1;

        // 1: lone demand
        @(posedge clock); #1 dm_req = 1'b1; dm_addr = 8'h05;
        sb.push_back('{2'b10, 1'b0, word(8'h05)});
        wait_sig("t1_ack", 0, 10, t);
        check_val("t1_ren_at_ack", {63'd0, mem_ren}, 64'd0);
        @(posedge clock); #1 dm_req = 1'b0;
        @(negedge clock);
        check_val("t1_ren_after_ack", {63'd0, mem_ren}, 64'd1);
        check_val("t1_mem_addr", {56'd0, mem_addr}, 64'h05);
        wait_sig("t1_ready", 6, 20, m);
        wait_sig("t1_valid", 2, 20, v);
        check_val("t1_valid_latency", 64'(v - m), 64'd1);
        @(negedge clock);
        check_val("t1_gap_ren", {63'd0, mem_ren}, 64'd0);

        // 2: simultaneous demand and prefetch
        @(posedge clock); #1 dm_req = 1'b1; dm_addr = 8'h03; pf_req = 1'b1; pf_addr = 8'h04;
        sb.push_back('{2'b10, 1'b0, word(8'h03)});
        sb.push_back('{2'b01, 1'b0, word(8'h04)});
        wait_sig("t2_dm_ack", 0, 10, t);
        check_val("t2_pf_ack_held", {63'd0, pf_ack}, 64'd0);
        @(posedge clock); #1 dm_req = 1'b0;
        wait_sig("t2_dm_valid", 2, 30, v);
        wait_sig("t2_pf_ack", 1, 30, t);
        check_val("t2_pf_ack_after_gap", 64'(t - v), 64'd3);
        @(posedge clock); #1 pf_req = 1'b0;
        wait_sig("t2_pf_valid", 3, 30, v);

        // 3 and 4: prefetch of 0x08 interrupted by a demand for 0x08 (promote) or 0x09 (abort)
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 8'h08 : 8'h09;
            repeat (2) @(posedge clock);
            #1 pf_req = 1'b1; pf_addr = 8'h08;
            wait_sig("t34_pf_ack", 1, 10, t);
            @(posedge clock); #1 pf_req = 1'b0;
            wait_sig("t34_ren", 4, 10, r);
            @(posedge clock); #1 dm_req = 1'b1; dm_addr = a;
            sb.push_back('{2'b10, 1'b0, word(a)});
            if (k == 0) begin
                wait_sig("t3_dm_ack", 0, 10, t);
                check_val("t3_dropped_with_ack", {63'd0, pf_dropped}, 64'd1);
                check_val("t3_ren_held", {63'd0, mem_ren}, 64'd1);
                @(posedge clock); #1 dm_req = 1'b0;
                lows = 0; n = 0;
                @(negedge clock);
                while (!dm_valid && n < 20) begin
                    if (!mem_ren) lows++;
                    @(negedge clock);
                    n++;
                end
                check_val("t3_dm_valid_seen", {63'd0, dm_valid}, 64'd1);
                check_val("t3_ren_low_cycles", 64'(lows), 64'd0);
            end else begin
                wait_sig("t4_dropped", 5, 10, t);
                check_val("t4_ren_dropped", {63'd0, mem_ren}, 64'd0);
                check_val("t4_no_ack_yet", {63'd0, dm_ack}, 64'd0);
                wait_sig("t4_dm_ack", 0, 10, t);
                @(posedge clock); #1 dm_req = 1'b0;
                wait_sig("t4_dm_valid", 2, 20, v);
            end
        end

        // 5: memory never ready -> timeout error
        repeat (2) @(posedge clock);
        #1 stub_low = 1'b1; dm_req = 1'b1; dm_addr = 8'h0A;
        sb.push_back('{2'b10, 1'b1, 32'd0});
        wait_sig("t5_ack", 0, 10, t);
        @(posedge clock); #1 dm_req = 1'b0;
        wait_sig("t5_ren", 4, 10, r);
        wait_sig("t5_valid", 2, 30, v);
        check_val("t5_timeout_cycles", 64'(v - r), 64'(TMO));
        @(posedge clock); #1 stub_low = 1'b0;

        // 6: reset during READ, then a fresh demand
        repeat (3) @(posedge clock);
        #1 dm_req = 1'b1; dm_addr = 8'h0C;
        wait_sig("t6_ack", 0, 10, t);
        @(posedge clock); #1 dm_req = 1'b0;
        wait_sig("t6_ren", 4, 10, r);
        #2 reset = 1'b0;
        #1;
        check_val("t6_async_outputs", {56'd0, dm_ack, dm_valid, pf_ack, pf_valid, pf_dropped, resp_err, mem_ren, busy}, 64'd0);
        check_val("t6_async_data", {24'd0, mem_addr, resp_data}, 64'd0);
        repeat (6) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 dm_req = 1'b1; dm_addr = 8'h0D;
        sb.push_back('{2'b10, 1'b0, word(8'h0D)});
        wait_sig("t6_fresh_ack", 0, 10, t);
        @(posedge clock); #1 dm_req = 1'b0;
        wait_sig("t6_fresh_valid", 2, 30, v);

        n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val("final_idle", {63'd0, busy}, 64'd0);
        check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
        check_val("drop_count", 64'(drops), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
